// File: rtl/keypad_scan_if.sv
// keypad_scan_if
//   Bundles the keypad matrix lines and the debounced key outputs.
//   master : keypad_scan side (samples rows, drives columns and key outputs)
//   slave  : keypad/consumer side (drives rows, observes columns and key outputs)
//   row_in        4  keypad rows, active-low, asynchronous
//   col_out       4  column drive, one bit low
//   keyboard_data 4  accepted key code, held after release
//   IsPressed     1  level, high while the accepted key is held
//   press_pulse   1  one-cycle strobe on acceptance
interface keypad_scan_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] keyboard_data;
   logic       IsPressed;
   logic       press_pulse;

   modport master (
      input  row_in,
      output col_out,
      output keyboard_data,
      output IsPressed,
      output press_pulse
   );

   modport slave (
      output row_in,
      input  col_out,
      input  keyboard_data,
      input  IsPressed,
      input  press_pulse
   );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x4 active-low matrix keypad one column at a time, classifies each
//   4-column frame as NONE / SINGLE(code) / MULTI, debounces frame results and
//   presents one accepted key with a level press flag and a press strobe.
//   sys_clk    in  system clock
//   sys_rst_n  in  asynchronous active-low reset
//   kp_bus     master modport of keypad_scan_if (rows in; columns, key code,
//              IsPressed, press_pulse out)
module keypad_scan #(
   parameter int unsigned SCAN_DIV        = 50_000,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   keypad_scan_if.master kp_bus
);

   localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);

   localparam logic [0:0] ST_RELEASED = 1'b0;
   localparam logic [0:0] ST_PRESSED  = 1'b1;

   logic [3:0]        r_row_s1;
   logic [3:0]        r_row_s2;
   logic [SLOT_W-1:0] r_slot;
   logic [1:0]        r_col;
   logic [1:0]        r_acc_cnt;     // closures so far this frame: 0, 1, 2 (= two or more)
   logic [3:0]        r_acc_code;
   logic              r_cand_valid;  // 1: SINGLE candidate, 0: NONE candidate
   logic [3:0]        r_cand_code;
   logic [CNT_W-1:0]  r_db_cnt;
   logic [0:0]        r_state;
   logic [3:0]        r_key_data;
   logic              r_pressed;
   logic              r_pulse;

   logic              w_sample;
   logic              w_frame_end;
   logic [3:0]        w_col_hits;
   logic [2:0]        w_col_cnt;
   logic [1:0]        w_col_row;
   logic [1:0]        w_tot_cnt;
   logic [3:0]        w_tot_code;
   logic              w_same;

   function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   assign w_sample    = (r_slot == SLOT_LAST);
   assign w_frame_end = w_sample && (r_col == 2'd3);
   assign w_col_hits  = ~r_row_s2;

   always_comb begin
      w_col_cnt = 3'd0;
      w_col_row = 2'd0;
      for (int unsigned r = 0; r < 4; r++) begin
         if (w_col_hits[r]) begin
            if (w_col_cnt == 3'd0) w_col_row = 2'(r);
            w_col_cnt = w_col_cnt + 3'd1;
         end
      end
   end

   // Running frame classification including the column being sampled now.
   always_comb begin
      w_tot_cnt  = 2'd0;
      w_tot_code = '0;
      if (r_acc_cnt == 2'd2 || w_col_cnt >= 3'd2 || (r_acc_cnt == 2'd1 && w_col_cnt != 3'd0)) begin
         w_tot_cnt = 2'd2;
      end else if (r_acc_cnt == 2'd1) begin
         w_tot_cnt  = 2'd1;
         w_tot_code = r_acc_code;
      end else if (w_col_cnt == 3'd1) begin
         w_tot_cnt  = 2'd1;
         w_tot_code = f_key_code(w_col_row, r_col);
      end
   end

   assign w_same = (w_tot_cnt == 2'd1) ? (r_cand_valid && (w_tot_code == r_cand_code))
                                       : !r_cand_valid;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_row_s1 <= '0;
         r_row_s2 <= '0;
      end else begin
         r_row_s1 <= kp_bus.row_in;
         r_row_s2 <= r_row_s1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_slot <= '0;
         r_col  <= '0;
      end else if (w_sample) begin
         r_slot <= '0;
         r_col  <= r_col + 2'd1;
      end else begin
         r_slot <= r_slot + SLOT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_acc_cnt  <= '0;
         r_acc_code <= '0;
      end else if (w_sample) begin
         if (r_col == 2'd3) begin
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
         end else begin
            r_acc_cnt  <= w_tot_cnt;
            r_acc_code <= w_tot_code;
         end
      end
   end

   // Debounce: MULTI frames wipe the candidate so they can never be accepted.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cand_valid <= 1'b0;
         r_cand_code  <= '0;
         r_db_cnt     <= '0;
      end else if (w_frame_end) begin
         if (w_tot_cnt == 2'd2) begin
            r_cand_valid <= 1'b0;
            r_cand_code  <= '0;
            r_db_cnt     <= '0;
         end else if (w_same) begin
            if (r_db_cnt != CNT_MAX) r_db_cnt <= r_db_cnt + CNT_W'(1);
         end else begin
            r_cand_valid <= (w_tot_cnt == 2'd1);
            r_cand_code  <= w_tot_code;
            r_db_cnt     <= CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_RELEASED;
         r_key_data <= '0;
         r_pressed  <= 1'b0;
         r_pulse    <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            ST_RELEASED: begin
               if (r_db_cnt == CNT_MAX && r_cand_valid) begin
                  r_state    <= ST_PRESSED;
                  r_key_data <= r_cand_code;
                  r_pressed  <= 1'b1;
                  r_pulse    <= 1'b1;
               end
            end
            default: begin
               if (r_db_cnt == CNT_MAX && !r_cand_valid) begin
                  r_state   <= ST_RELEASED;
                  r_pressed <= 1'b0;
               end
            end
         endcase
      end
   end

   assign kp_bus.col_out       = ~(4'b0001 << r_col);
   assign kp_bus.keyboard_data = r_key_data;
   assign kp_bus.IsPressed     = r_pressed;
   assign kp_bus.press_pulse   = r_pulse;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3.
//   A keypad model shorts a row to the driven column for every closed key; a
//   frame-level reference model predicts all outputs every cycle.
module tb_keypad_scan;

   localparam int SD    = 4;
   localparam int DF    = 3;
   localparam int FRAME = 4 * SD;
   localparam int LAT   = (DF + 1) * FRAME + 3;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] keys      = '0;    // bit r*4+c: key at row r, column c closed

   int n_checks = 0;
   int n_fail   = 0;

   keypad_scan_if kif ();

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .kp_bus    (kif)
   );

   always #5 sys_clk = ~sys_clk;

   assign kif.row_in = {~|(keys[15:12] & ~kif.col_out), ~|(keys[11:8] & ~kif.col_out),
                        ~|(keys[7:4]   & ~kif.col_out), ~|(keys[3:0]  & ~kif.col_out)};

   logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   // Reference model: keys seen two edges late, one column per SD cycles,
   // frame verdicts from the closure count, run-length debounce.
   int unsigned m_cyc       = 0;
   logic [15:0] m_h1        = '0;
   logic [15:0] m_h2        = '0;
   logic [15:0] m_fmask     = '0;
   int          m_cand_kind = 0;
   logic [3:0]  m_cand_code = '0;
   int          m_run       = 0;
   bit          m_pending   = 0;
   logic [3:0]  m_col       = 4'b1110;
   logic [3:0]  m_data      = '0;
   logic        m_pressed   = 1'b0;
   logic        m_pulse     = 1'b0;

   logic [9:0] w_obs;
   logic [9:0] w_exp;
   assign w_obs = {kif.col_out, kif.IsPressed, kif.keyboard_data, kif.press_pulse};
   assign w_exp = {m_col, m_pressed, m_data, m_pulse};

   initial begin : ref_model
      int n, kind, c;
      logic [3:0] code;
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (!sys_rst_n) begin
            m_cyc = 0; m_h1 = '0; m_h2 = '0; m_fmask = '0;
            m_cand_kind = 0; m_cand_code = '0; m_run = 0; m_pending = 0;
            m_col = 4'b1110; m_data = '0; m_pressed = 1'b0; m_pulse = 1'b0;
         end else begin
            m_pulse = 1'b0;
            if (m_pending) begin
               m_pending = 0;
               if (!m_pressed && m_run == DF && m_cand_kind == 1) begin
                  m_pressed = 1'b1; m_data = m_cand_code; m_pulse = 1'b1;
               end else if (m_pressed && m_run == DF && m_cand_kind == 0) begin
                  m_pressed = 1'b0;
               end
            end
            c = int'((m_cyc / SD) % 4);
            if (m_cyc % SD == SD - 1) begin
               m_fmask = m_fmask | (m_h2 & (16'h1111 << c));
               if (c == 3) begin
                  n = $countones(m_fmask);
                  kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
                  code = '0;
                  for (int i = 0; i < 16; i++) if (m_fmask[i]) code = KMAP[i];
                  if (kind == 2) begin
                     m_cand_kind = 0; m_cand_code = '0; m_run = 0;
                  end else if (kind == m_cand_kind && (kind == 0 || code == m_cand_code)) begin
                     if (m_run < DF) m_run = m_run + 1;
                  end else begin
                     m_cand_kind = kind; m_cand_code = code; m_run = 1;
                  end
                  m_pending = 1;
                  m_fmask = '0;
               end
            end
            m_h2 = m_h1;
            m_h1 = keys;
            m_cyc = m_cyc + 1;
            m_col = ~(4'b0001 << ((m_cyc / SD) % 4));
         end
      end
   end

   task automatic test_reset();
      logic [3:0] walk;
      sys_rst_n = 1'b0;
      keys = '0;
      repeat (3) @(negedge sys_clk);
      n_checks++;
      if (kif.col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", kif.col_out); end
      n_checks++;
      if (kif.keyboard_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", kif.keyboard_data); end
      n_checks++;
      if (kif.IsPressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed: got %b expected 0", kif.IsPressed); end
      n_checks++;
      if (kif.press_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", kif.press_pulse); end
      sys_rst_n = 1'b1;
      for (int k = 1; k <= 2 * FRAME; k++) begin
         @(negedge sys_clk);
         walk = 4'b0001 << ((k / SD) % 4);
         n_checks++;
         if (kif.col_out !== ~walk) begin n_fail++; $display("FAIL col_walk: cycle %0d got %b expected %b", k, kif.col_out, ~walk); end
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL reset_model: got %h expected %h", w_obs, w_exp); end
      end
   endtask

   task automatic test_clean_press();
      int rise, fall, pulses;
      for (int k = 0; k < FRAME && (m_cyc % FRAME) != 0; k++) @(negedge sys_clk);
      keys = 16'h8000;   // r3 c3 -> D
      rise = -1; pulses = 0;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL clean_model: cycle %0d got %h expected %h", k, w_obs, w_exp); end
         if (kif.press_pulse) pulses++;
         if (kif.IsPressed && rise < 0) rise = k;
      end
      n_checks++;
      if (rise < 1 || rise > LAT) begin n_fail++; $display("FAIL clean_latency: got %0d expected 1..%0d", rise, LAT); end
      n_checks++;
      if (kif.keyboard_data !== 4'hD) begin n_fail++; $display("FAIL clean_data: got %h expected d", kif.keyboard_data); end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL clean_pulses: got %0d expected 1", pulses); end
      keys = '0;
      fall = -1; pulses = 0;
      for (int k = 1; k <= LAT + FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL release_model: cycle %0d got %h expected %h", k, w_obs, w_exp); end
         if (kif.press_pulse) pulses++;
         if (!kif.IsPressed && fall < 0) fall = k;
      end
      n_checks++;
      if (fall < 1) begin n_fail++; $display("FAIL release_latency: got %0d expected 1..%0d", fall, LAT + FRAME); end
      n_checks++;
      if (kif.keyboard_data !== 4'hD || pulses != 0) begin
         n_fail++; $display("FAIL release_hold: got data %h pulses %0d expected d 0", kif.keyboard_data, pulses);
      end
   endtask

   task automatic test_bounce();
      int rise, fall, idle;
      idle = $urandom_range(0, FRAME - 1);
      repeat (idle) @(negedge sys_clk);
      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0) keys[4] = ~keys[4];   // r1 c0 -> 4
         @(negedge sys_clk);
         n_checks++;
         if (kif.IsPressed !== 1'b0 || kif.press_pulse !== 1'b0) begin
            n_fail++; $display("FAIL bounce_quiet: got pressed %b pulse %b expected 0 0", kif.IsPressed, kif.press_pulse);
         end
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL bounce_model: got %h expected %h", w_obs, w_exp); end
      end
      keys = 16'h0010;
      rise = -1;
      for (int k = 1; k <= LAT + FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL bounce_hold_model: got %h expected %h", w_obs, w_exp); end
         if (kif.IsPressed && rise < 0) rise = k;
      end
      n_checks++;
      if (rise < 0 || kif.keyboard_data !== 4'h4) begin
         n_fail++; $display("FAIL bounce_accept: got rise %0d data %h expected press with 4", rise, kif.keyboard_data);
      end
      keys = '0;
      fall = -1;
      for (int k = 1; k <= LAT + FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL bounce_release_model: got %h expected %h", w_obs, w_exp); end
         if (!kif.IsPressed && fall < 0) fall = k;
      end
      n_checks++;
      if (fall < 0) begin n_fail++; $display("FAIL bounce_release: got IsPressed 1 expected 0"); end
   endtask

   task automatic test_rollover();
      int rise, fall, pulses;
      keys = 16'h0001;   // key 1
      rise = -1;
      for (int k = 1; k <= LAT + FRAME && rise < 0; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL roll_press_model: got %h expected %h", w_obs, w_exp); end
         if (kif.IsPressed) rise = k;
      end
      n_checks++;
      if (rise < 0 || kif.keyboard_data !== 4'h1) begin
         n_fail++; $display("FAIL roll_accept: got rise %0d data %h expected press with 1", rise, kif.keyboard_data);
      end
      pulses = 0;
      for (int ph = 0; ph < 2; ph++) begin
         keys = (ph == 0) ? 16'h0003 : 16'h0002;   // 1+2 held, then only 2
         for (int k = 0; k < 6 * FRAME; k++) begin
            @(negedge sys_clk);
            if (kif.press_pulse) pulses++;
            n_checks++;
            if ({kif.IsPressed, kif.keyboard_data, kif.press_pulse} !== {1'b1, 4'h1, 1'b0}) begin
               n_fail++;
               $display("FAIL roll_hold: phase %0d got %b/%h/%b expected 1/1/0", ph, kif.IsPressed, kif.keyboard_data, kif.press_pulse);
            end
            n_checks++;
            if (w_obs !== w_exp) begin n_fail++; $display("FAIL roll_model: got %h expected %h", w_obs, w_exp); end
         end
      end
      keys = '0;
      fall = -1;
      for (int k = 1; k <= LAT + FRAME; k++) begin
         @(negedge sys_clk);
         if (kif.press_pulse) pulses++;
         if (!kif.IsPressed && fall < 0) fall = k;
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL roll_release_model: got %h expected %h", w_obs, w_exp); end
      end
      n_checks++;
      if (fall < 0 || kif.keyboard_data !== 4'h1 || pulses != 0) begin
         n_fail++; $display("FAIL roll_release: got fall %0d data %h pulses %0d expected fall, 1, 0", fall, kif.keyboard_data, pulses);
      end
   endtask

   task automatic test_simultaneous();
      int a, b;
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      keys = (16'h0001 << a) | (16'h0001 << b);
      for (int k = 0; k < 8 * FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (kif.IsPressed !== 1'b0 || kif.press_pulse !== 1'b0) begin
            n_fail++; $display("FAIL multi_quiet: keys %0d,%0d got pressed %b pulse %b expected 0 0", a, b, kif.IsPressed, kif.press_pulse);
         end
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL multi_model: got %h expected %h", w_obs, w_exp); end
      end
      keys = '0;
      for (int k = 0; k < 5 * FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL multi_idle_model: got %h expected %h", w_obs, w_exp); end
      end
   endtask

   task automatic test_mid_reset();
      int a, rise, fall, pulses;
      a = $urandom_range(0, 15);
      keys = 16'h0001 << a;
      rise = -1;
      for (int k = 1; k <= LAT + FRAME && rise < 0; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL mrst_press_model: got %h expected %h", w_obs, w_exp); end
         if (kif.IsPressed) rise = k;
      end
      n_checks++;
      if (rise < 0) begin n_fail++; $display("FAIL mrst_first_press: got IsPressed 0 expected 1"); end
      repeat ($urandom_range(1, 10)) @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if (w_obs !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
         n_fail++; $display("FAIL mrst_async: got %h expected %h", w_obs, {4'b1110, 1'b0, 4'h0, 1'b0});
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      rise = -1; pulses = 0;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL mrst_model: got %h expected %h", w_obs, w_exp); end
         if (kif.press_pulse) pulses++;
         if (kif.IsPressed && rise < 0) rise = k;
      end
      n_checks++;
      if (rise < 1 || rise > LAT || pulses != 1 || kif.keyboard_data !== KMAP[a]) begin
         n_fail++;
         $display("FAIL mrst_reaccept: got rise %0d pulses %0d data %h expected <=%0d 1 %h", rise, pulses, kif.keyboard_data, LAT, KMAP[a]);
      end
      keys = '0;
      fall = -1;
      for (int k = 1; k <= LAT + FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL mrst_release_model: got %h expected %h", w_obs, w_exp); end
         if (!kif.IsPressed && fall < 0) fall = k;
      end
      n_checks++;
      if (fall < 0) begin n_fail++; $display("FAIL mrst_release: got IsPressed 1 expected 0"); end
   endtask

   task automatic test_random_soak();
      int hold, nk;
      for (int seg = 0; seg < 40; seg++) begin
         nk = $urandom_range(0, 2);
         keys = '0;
         for (int j = 0; j < nk; j++) keys = keys | (16'h0001 << $urandom_range(0, 15));
         hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 12) : $urandom_range(40, 90);
         for (int k = 0; k < hold; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if (w_obs !== w_exp) begin n_fail++; $display("FAIL soak_model: seg %0d keys %h got %h expected %h", seg, keys, w_obs, w_exp); end
         end
      end
      keys = '0;
      for (int k = 0; k < 6 * FRAME; k++) begin
         @(negedge sys_clk);
         n_checks++;
         if (w_obs !== w_exp) begin n_fail++; $display("FAIL soak_idle_model: got %h expected %h", w_obs, w_exp); end
      end
      n_checks++;
      if (kif.IsPressed !== 1'b0) begin n_fail++; $display("FAIL soak_final: got IsPressed %b expected 0", kif.IsPressed); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_rollover();
      test_simultaneous();
      test_mid_reset();
      test_random_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
